// File: rtl/uart_rx_cfg_if.sv
// Serial-line receive bundle for uart_rx_cfg.
// master drives the line, slave returns the decoded frame.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 rs232_rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 po_flag;
  logic                 parity_err;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (
    output rs232_rx,
    input  rx_data,
    input  po_flag,
    input  parity_err,
    input  frame_err,
    input  rx_busy
  );

  modport slave (
    input  rs232_rx,
    output rx_data,
    output po_flag,
    output parity_err,
    output frame_err,
    output rx_busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with 3-sample majority voting,
// optional parity and 1 or 2 checked stop bits.
module uart_rx_cfg #(
  parameter int BAUD_END   = 5208,
  parameter int BAUD_M     = BAUD_END/2-1,
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_cfg_if.slave  bus
);

  localparam int CW = $clog2(BAUD_END);
  localparam logic [CW-1:0] C_END = CW'(BAUD_END-1);
  localparam logic [CW-1:0] C_S0  = CW'(BAUD_M-1);
  localparam logic [CW-1:0] C_S1  = CW'(BAUD_M);
  localparam logic [CW-1:0] C_DEC = CW'(BAUD_M+1);
  localparam logic [3:0]    C_DB  = 4'(DATA_BITS-1);
  localparam logic [3:0]    C_SB  = 4'(STOP_BITS-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 dly_q;
  state_e               state_q;
  logic [CW-1:0]        cnt0_q;
  logic [3:0]           cnt1_q;
  logic [1:0]           vote_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_q;
  logic                 pacc_q;
  logic                 facc_q;
  logic                 po_q;
  logic                 perr_q;
  logic                 ferr_q;

  logic start_edge_d;
  logic bit_d;
  logic wrap_d;
  logic decide_d;

  assign start_edge_d = ~sync2_q & dly_q;
  assign bit_d  = (vote_q[0] & vote_q[1])
                | (vote_q[0] & sync2_q)
                | (vote_q[1] & sync2_q);
  assign wrap_d   = (cnt0_q == C_END);
  assign decide_d = (cnt0_q == C_DEC);

  // Reset to idle-high so releasing reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dly_q   <= 1'b1;
    end else begin
      sync1_q <= bus.rs232_rx;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      vote_q  <= '1;
      shift_q <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      pacc_q  <= 1'b0;
      facc_q  <= 1'b0;
      po_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      po_q <= 1'b0;
      if (state_q != S_IDLE)
        cnt0_q <= wrap_d ? '0 : cnt0_q + 1'b1;
      if (cnt0_q == C_S0) vote_q[0] <= sync2_q;
      if (cnt0_q == C_S1) vote_q[1] <= sync2_q;
      unique case (state_q)
        S_IDLE: begin
          if (start_edge_d) begin
            state_q <= S_START;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            par_q   <= 1'b0;
            pacc_q  <= 1'b0;
            facc_q  <= 1'b0;
          end
        end
        S_START: begin
          if (decide_d && bit_d) begin
            state_q <= S_IDLE;
            cnt0_q  <= '0;
          end else if (wrap_d) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (decide_d) begin
            shift_q <= {bit_d, shift_q[DATA_BITS-1:1]};
            par_q   <= par_q ^ bit_d;
          end
          if (wrap_d) begin
            if (cnt1_q == C_DB) begin
              cnt1_q  <= '0;
              state_q <= PARITY_EN ? S_PARITY : S_STOP;
            end else begin
              cnt1_q <= cnt1_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (decide_d)
            pacc_q <= ((par_q ^ bit_d) != PARITY_ODD);
          if (wrap_d)
            state_q <= S_STOP;
        end
        S_STOP: begin
          // Leave mid-bit: the second half of the stop bit is resync margin.
          if (decide_d) begin
            if (cnt1_q == C_SB) begin
              state_q <= S_IDLE;
              cnt0_q  <= '0;
              cnt1_q  <= '0;
              po_q    <= 1'b1;
              data_q  <= shift_q;
              perr_q  <= PARITY_EN & pacc_q;
              ferr_q  <= facc_q | ~bit_d;
            end else begin
              facc_q <= facc_q | ~bit_d;
            end
          end else if (wrap_d) begin
            cnt1_q <= cnt1_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_data    = data_q;
  assign bus.po_flag    = po_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 7O1 and 8N2 instances
// at 16 clocks per bit.
module tb_uart_rx_cfg;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  int           na, nb, nc;
  logic [7:0]   prev_a;
  logic [7:0]   last_a;

  uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if_b ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if_c ();

  uart_rx_cfg #(
    .BAUD_END(16)
  ) u_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  uart_rx_cfg #(
    .BAUD_END   (16),
    .DATA_BITS  (7),
    .PARITY_EN  (1'b1),
    .PARITY_ODD (1'b1)
  ) u_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  uart_rx_cfg #(
    .BAUD_END  (16),
    .STOP_BITS (2)
  ) u_c (
    .clk (clk),
    .rst (rst),
    .bus (if_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (if_a.po_flag) begin
      na++;
      prev_a = last_a;
      last_a = if_a.rx_data;
    end
    if (if_b.po_flag) nb++;
    if (if_c.po_flag) nc++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int d, input logic v);
    case (d)
      0: if_a.rs232_rx = v;
      1: if_b.rs232_rx = v;
      default: if_c.rs232_rx = v;
    endcase
  endtask

  // bits are LSB first; spk flips one cycle at the centre of that bit
  task automatic send(input int d, input logic [15:0] bits,
                      input int n, input int spk);
    logic v;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 16; c++) begin
        v = bits[i];
        if (i == spk && c == 8) v = ~v;
        set_line(d, v);
        @(negedge clk);
      end
    end
    set_line(d, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_line(0, 1'b1);
    set_line(1, 1'b1);
    set_line(2, 1'b1);
    idle(3);
    vecs++;
    if (if_a.rx_data !== 8'h00) begin
      errs++;
      $display("FAIL rst_data got %h want 00", if_a.rx_data);
    end
    vecs++;
    if ({if_a.po_flag, if_a.parity_err, if_a.frame_err, if_a.rx_busy}
        !== 4'b0000) begin
      errs++;
      $display("FAIL rst_flags_a got %b want 0000",
        {if_a.po_flag, if_a.parity_err, if_a.frame_err, if_a.rx_busy});
    end
    vecs++;
    if ({if_b.rx_busy, if_c.rx_busy, if_b.rx_data} !== 9'h000) begin
      errs++;
      $display("FAIL rst_bc got %h want 000",
        {if_b.rx_busy, if_c.rx_busy, if_b.rx_data});
    end
    rst = 1'b0;
    idle(20);
    vecs++;
    if ({na, nb, nc} !== {32'd0, 32'd0, 32'd0} || if_a.rx_busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_release got %0d/%0d/%0d busy %b want 0/0/0 0",
        na, nb, nc, if_a.rx_busy);
    end
  endtask

  task automatic test_basic;
    int n0;
    n0 = na;
    send(0, {6'h0, 1'b1, 8'hA5, 1'b0}, 10, -1);
    idle(8);
    vecs++;
    if (na !== n0 + 1) begin
      errs++;
      $display("FAIL basic_count got %0d want %0d", na, n0 + 1);
    end
    vecs++;
    if (if_a.rx_data !== 8'hA5) begin
      errs++;
      $display("FAIL basic_data got %h want a5", if_a.rx_data);
    end
    vecs++;
    if ({if_a.parity_err, if_a.frame_err, if_a.rx_busy} !== 3'b000) begin
      errs++;
      $display("FAIL basic_flags got %b want 000",
        {if_a.parity_err, if_a.frame_err, if_a.rx_busy});
    end
  endtask

  task automatic test_glitch;
    int n0;
    n0 = na;
    set_line(0, 1'b0);
    idle(4);
    set_line(0, 1'b1);
    idle(3);
    vecs++;
    if (if_a.rx_busy !== 1'b1) begin
      errs++;
      $display("FAIL glitch_busy got %b want 1", if_a.rx_busy);
    end
    idle(20);
    vecs++;
    if (na !== n0 || if_a.rx_busy !== 1'b0) begin
      errs++;
      $display("FAIL glitch_idle got %0d busy %b want %0d 0",
        na, if_a.rx_busy, n0);
    end
    vecs++;
    if (if_a.rx_data !== 8'hA5) begin
      errs++;
      $display("FAIL glitch_data got %h want a5", if_a.rx_data);
    end
  endtask

  task automatic test_break;
    int n0;
    n0 = na;
    set_line(0, 1'b0);
    idle(16 * 12);
    vecs++;
    if (na !== n0 + 1) begin
      errs++;
      $display("FAIL break_count got %0d want %0d", na, n0 + 1);
    end
    vecs++;
    if ({if_a.rx_data, if_a.frame_err, if_a.rx_busy} !== {8'h00, 2'b10}) begin
      errs++;
      $display("FAIL break_frame got %h want 002",
        {if_a.rx_data, if_a.frame_err, if_a.rx_busy});
    end
    set_line(0, 1'b1);
    idle(40);
    vecs++;
    if (na !== n0 + 1 || if_a.rx_busy !== 1'b0) begin
      errs++;
      $display("FAIL break_release got %0d busy %b want %0d 0",
        na, if_a.rx_busy, n0 + 1);
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    n0 = na;
    send(0, {6'h0, 1'b1, 8'h00, 1'b0}, 10, -1);
    send(0, {6'h0, 1'b1, 8'hFF, 1'b0}, 10, -1);
    idle(8);
    vecs++;
    if (na !== n0 + 2) begin
      errs++;
      $display("FAIL b2b_count got %0d want %0d", na, n0 + 2);
    end
    vecs++;
    if ({prev_a, last_a} !== 16'h00FF) begin
      errs++;
      $display("FAIL b2b_data got %h want 00ff", {prev_a, last_a});
    end
    vecs++;
    if (if_a.frame_err !== 1'b0) begin
      errs++;
      $display("FAIL b2b_ferr got %b want 0", if_a.frame_err);
    end
  endtask

  task automatic test_reset_midframe;
    int n0;
    n0 = na;
    send(0, {6'h0, 1'b1, 8'h5A, 1'b0}, 3, -1);
    set_line(0, 1'b0);
    idle(6);
    rst = 1'b1;
    set_line(0, 1'b1);
    idle(2);
    vecs++;
    if ({if_a.rx_data, if_a.po_flag, if_a.parity_err,
         if_a.frame_err, if_a.rx_busy} !== 12'h000) begin
      errs++;
      $display("FAIL midrst_out got %h want 000",
        {if_a.rx_data, if_a.po_flag, if_a.parity_err,
         if_a.frame_err, if_a.rx_busy});
    end
    rst = 1'b0;
    idle(30);
    vecs++;
    if (na !== n0 || if_a.rx_busy !== 1'b0) begin
      errs++;
      $display("FAIL midrst_abort got %0d busy %b want %0d 0",
        na, if_a.rx_busy, n0);
    end
    send(0, {6'h0, 1'b1, 8'h81, 1'b0}, 10, -1);
    idle(8);
    vecs++;
    if (na !== n0 + 1 || if_a.rx_data !== 8'h81) begin
      errs++;
      $display("FAIL midrst_next got %0d/%h want %0d/81",
        na, if_a.rx_data, n0 + 1);
    end
  endtask

  task automatic test_parity;
    int n0;
    n0 = nb;
    send(1, {6'h0, 1'b1, 1'b1, 7'h55, 1'b0}, 10, -1);
    idle(8);
    vecs++;
    if (nb !== n0 + 1 || if_b.rx_data !== 7'h55) begin
      errs++;
      $display("FAIL par_ok got %0d/%h want %0d/55",
        nb, if_b.rx_data, n0 + 1);
    end
    vecs++;
    if (if_b.parity_err !== 1'b0) begin
      errs++;
      $display("FAIL par_ok_err got %b want 0", if_b.parity_err);
    end
    send(1, {6'h0, 1'b1, 1'b0, 7'h55, 1'b0}, 10, -1);
    idle(8);
    vecs++;
    if (nb !== n0 + 2 || if_b.rx_data !== 7'h55) begin
      errs++;
      $display("FAIL par_bad got %0d/%h want %0d/55",
        nb, if_b.rx_data, n0 + 2);
    end
    vecs++;
    if ({if_b.parity_err, if_b.frame_err} !== 2'b10) begin
      errs++;
      $display("FAIL par_bad_err got %b want 10",
        {if_b.parity_err, if_b.frame_err});
    end
  endtask

  task automatic test_stop2;
    int n0;
    n0 = nc;
    send(2, {5'h0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11, -1);
    idle(8);
    vecs++;
    if (nc !== n0 + 1 || if_c.rx_data !== 8'h3C) begin
      errs++;
      $display("FAIL stop2_frame got %0d/%h want %0d/3c",
        nc, if_c.rx_data, n0 + 1);
    end
    vecs++;
    if ({if_c.frame_err, if_c.parity_err} !== 2'b10) begin
      errs++;
      $display("FAIL stop2_ferr got %b want 10",
        {if_c.frame_err, if_c.parity_err});
    end
    send(2, {5'h0, 2'b11, 8'h3C, 1'b0}, 11, 3);
    idle(8);
    vecs++;
    if (nc !== n0 + 2 || if_c.rx_data !== 8'h3C) begin
      errs++;
      $display("FAIL spike_data got %0d/%h want %0d/3c",
        nc, if_c.rx_data, n0 + 2);
    end
    vecs++;
    if (if_c.frame_err !== 1'b0) begin
      errs++;
      $display("FAIL spike_ferr got %b want 0", if_c.frame_err);
    end
  endtask

  initial begin
    vecs   = 0;
    errs   = 0;
    na     = 0;
    nb     = 0;
    nc     = 0;
    prev_a = 8'h00;
    last_a = 8'h00;
    rst    = 1'b1;
    if_a.rs232_rx = 1'b1;
    if_b.rs232_rx = 1'b1;
    if_c.rs232_rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_midframe();
    test_parity();
    test_stop2();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter BAUD_END, default 5208, meaning clock cycles per bit period; legal range is at least 8.
REQ-002 The block SHALL have parameter BAUD_M, default BAUD_END/2-1, meaning the centre-sample index within a bit period.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range is 5..9.
REQ-004 The block SHALL have parameter PARITY_EN, default 0, meaning 1 = a parity bit follows the data.
REQ-005 The block SHALL have parameter PARITY_ODD, default 0, meaning 1 = odd parity and 0 = even parity; it is ignored when PARITY_EN=0.
REQ-006 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values are 1 and 2.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port rs232_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-010 The block SHALL have port rx_data, output, DATA_BITS bits: last received word, LSB first on the line.
REQ-011 The block SHALL have port po_flag, output, 1 bit: one-cycle strobe marking a completed frame.
REQ-012 The block SHALL have port parity_err, output, 1 bit: parity result of the frame flagged by po_flag.
REQ-013 The block SHALL have port frame_err, output, 1 bit: stop-bit result of the frame flagged by po_flag.
REQ-014 The block SHALL have port rx_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 rs232_rx SHALL pass through a 2-flop synchroniser plus one delay flop; a start edge SHALL be the synchronised level 0 while the delayed level is 1.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-017 In IDLE, a start edge SHALL move the FSM to START with bit counter cnt0=0.
REQ-018 cnt0 SHALL run 0..BAUD_END-1 and wrap while the FSM is not in IDLE; cnt1 SHALL count bits within the DATA and STOP states.
REQ-019 Each bit SHALL be decided by a 2-of-3 majority vote of the synchronised line sampled at cnt0 = BAUD_M-1, BAUD_M and BAUD_M+1; the decision is made at cnt0 = BAUD_M+1.
REQ-020 In START, a majority of 1 SHALL be a false start: the FSM returns to IDLE, and po_flag and all outputs stay unchanged.
REQ-021 In START, a majority of 0 SHALL move the FSM to DATA when cnt0 wraps.
REQ-022 In DATA, the voted bits SHALL shift into rx_data LSB first; after DATA_BITS bits the FSM SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-023 In PARITY, the voted bit SHALL be checked: parity_err = (XOR of data bits XOR parity bit) != PARITY_ODD.
REQ-024 In STOP, any stop bit with a majority of 0 SHALL set frame_err for the frame.
REQ-025 At the decision point of the last stop bit, the FSM SHALL update rx_data, parity_err and frame_err, pulse po_flag high for exactly one cycle, and return to IDLE.
REQ-026 After REQ-025, the FSM SHALL be able to accept a new start edge in the very next cycle; half a stop bit is the resynchronisation margin.
REQ-027 parity_err SHALL be 0 whenever PARITY_EN=0.
REQ-028 rx_data, parity_err and frame_err SHALL hold their values until the next po_flag.
REQ-029 Line edges seen in any state other than IDLE SHALL be ignored except by the majority sampling.
REQ-030 A frame that ends with frame_err=1 SHALL still produce po_flag.
REQ-031 A line held at 0 (break) SHALL produce one frame with rx_data=0 and frame_err=1, then no new frame until the line returns high and falls again.

Reset
REQ-032 While rst=1 at a clk edge, the FSM SHALL go to IDLE with cnt0=0 and cnt1=0.
REQ-033 While rst=1 at a clk edge, the synchroniser flops SHALL be set to all 1 so that no start edge is seen at reset release.
REQ-034 While rst=1 at a clk edge, rx_data=0, po_flag=0, parity_err=0, frame_err=0 and rx_busy=0.
REQ-035 A reset asserted mid-frame SHALL abort the frame with no po_flag; reception SHALL resume only on the next start edge after rst deasserts.

Verification
REQ-036 BAUD_END=16, 8N1, send 0xA5 -> exactly one po_flag; rx_data=8'hA5, parity_err=0, frame_err=0; rx_busy low afterwards.
REQ-037 BAUD_END=16, DATA_BITS=7, PARITY_EN=1, PARITY_ODD=1: send 0x55 with correct parity, then with the parity bit flipped -> two po_flags; rx_data=7'h55 both times; parity_err=0 and then 1.
REQ-038 BAUD_END=16: a 4-cycle low glitch on an idle line -> false start; no po_flag; FSM back in IDLE; rx_data unchanged.
REQ-039 BAUD_END=16, STOP_BITS=2: send 0x3C with the second stop bit low -> po_flag with rx_data=8'h3C and frame_err=1; a one-cycle spike at the centre sample of a data bit does not change the received value.
REQ-040 BAUD_END=16, 8N1: back-to-back frames 0x00 then 0xFF with no idle gap -> two po_flags, data correct; then assert rst during bit 3 of a third frame -> no po_flag, all outputs 0, and the next frame 0x81 is received correctly.
